// File: rtl/wall_map_writer_pkg.sv
// Shared constants, types and helpers for the wall bitmap write path.
package wall_pkg;

  localparam int ROW_W    = 640;  // bits per wall row (screen width)
  localparam int NUM_ROWS = 480;  // rows in wall RAM (screen height)
  localparam int BLK      = 16;   // block edge in pixels
  localparam int ADDR_W   = 10;   // row address / coordinate width

  typedef logic [ROW_W-1:0]  wall_row_t;
  typedef logic [ADDR_W-1:0] coord_t;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD   = 3'd1,
    WAIT = 3'd2,
    WR   = 3'd3,
    DONE = 3'd4
  } writer_state_t;

  // A block command is legal only if its top-left pixel lies on screen.
  function automatic logic cmd_in_range(input coord_t x, input coord_t y);
    return (x < coord_t'(ROW_W)) && (y < coord_t'(NUM_ROWS));
  endfunction

endpackage

// File: rtl/wall_map_writer_if.sv
// Command handshake, wall RAM port and status flags of the wall map writer.
interface wall_map_writer_if;
  import wall_pkg::*;

  logic      Cmd_Valid;
  logic      Cmd_Ready;
  logic      Cmd_Op;
  coord_t    Cmd_X;
  coord_t    Cmd_Y;
  coord_t    Ram_Addr;
  logic      Ram_Rd_En;
  wall_row_t Ram_Rd_Data;
  logic      Ram_Wr_En;
  wall_row_t Ram_Wr_Data;
  logic      Busy;
  logic      Done;
  logic      Err;

  // Writer side.
  modport slave (
    input  Cmd_Valid, Cmd_Op, Cmd_X, Cmd_Y, Ram_Rd_Data,
    output Cmd_Ready, Ram_Addr, Ram_Rd_En, Ram_Wr_En, Ram_Wr_Data, Busy, Done, Err
  );

  // Requester / RAM side.
  modport master (
    output Cmd_Valid, Cmd_Op, Cmd_X, Cmd_Y, Ram_Rd_Data,
    input  Cmd_Ready, Ram_Addr, Ram_Rd_En, Ram_Wr_En, Ram_Wr_Data, Busy, Done, Err
  );

endinterface

// File: rtl/wall_map_writer_row_mask.sv
// Column mask for one 16-pixel-wide block, clipped at the right screen edge.
module wall_row_mask
  import wall_pkg::*;
(
  input  coord_t    x,
  output wall_row_t mask
);

  logic [10:0] lo_s;
  logic [10:0] hi_s;

  // 11-bit bounds so x+15 never wraps; columns past ROW_W-1 simply do not exist.
  always_comb begin
    lo_s = {1'b0, x};
    hi_s = {1'b0, x} + 11'(BLK - 1);
    mask = '0;
    for (int i = 0; i < ROW_W; i++) begin
      mask[i] = (11'(i) >= lo_s) && (11'(i) <= hi_s);
    end
  end

endmodule

// File: rtl/wall_map_writer.sv
// Row-by-row read-modify-write of a 16x16 set/clear block into the wall RAM.
module wall_map_writer
  import wall_pkg::*;
(
  input  logic               Clk,
  input  logic               Reset_n,
  wall_map_writer_if.slave   bus
);

  writer_state_t state_r, next_state_s;

  logic      op_r;
  coord_t    x_r, y_r;
  logic [3:0] row_r;
  wall_row_t mask_s;
  logic      cmd_ok_s, last_row_s;

  logic      rdy_r, busy_r, done_r, err_r, rd_en_r, wr_en_r;
  coord_t    addr_r;
  wall_row_t wr_data_r;

  logic      rdy_s, busy_s, done_s, err_s, rd_en_s, wr_en_s;
  coord_t    addr_s;
  wall_row_t wr_data_s;

  wall_row_mask u_mask (.x(x_r), .mask(mask_s));

  assign cmd_ok_s   = cmd_in_range(bus.Cmd_X, bus.Cmd_Y);
  // In WR the address register holds Y+row, so it doubles as the bottom-edge test.
  assign last_row_s = (row_r == 4'(BLK - 1)) || (addr_r == coord_t'(NUM_ROWS - 1));

  // State register.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state logic; Cmd_Ready is high exactly in IDLE, so Cmd_Valid alone accepts there.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE: begin
        if (bus.Cmd_Valid) begin
          if (cmd_ok_s) begin
            next_state_s = RD;
          end else begin
            next_state_s = DONE;
          end
        end else begin
          next_state_s = IDLE;
        end
      end
      RD:   next_state_s = WAIT;
      WAIT: next_state_s = WR;
      WR: begin
        if (last_row_s) begin
          next_state_s = DONE;
        end else begin
          next_state_s = RD;
        end
      end
      DONE:    next_state_s = IDLE;
      default: next_state_s = IDLE;
    endcase
  end

  // Output values for the coming cycle, decoded from the next state so all outputs are registered.
  always_comb begin
    rdy_s     = (next_state_s == IDLE);
    busy_s    = (next_state_s != IDLE);
    done_s    = (next_state_s == DONE);
    err_s     = (state_r == IDLE) && (next_state_s == DONE);
    rd_en_s   = 1'b0;
    wr_en_s   = 1'b0;
    addr_s    = addr_r;
    wr_data_s = wr_data_r;
    case (next_state_s)
      RD: begin
        rd_en_s = 1'b1;
        if (state_r == IDLE) begin
          addr_s = bus.Cmd_Y;
        end else begin
          addr_s = coord_t'(y_r + coord_t'(row_r) + 10'd1);
        end
      end
      WR: begin
        wr_en_s = 1'b1;
        if (op_r) begin
          wr_data_s = bus.Ram_Rd_Data | mask_s;
        end else begin
          wr_data_s = bus.Ram_Rd_Data & ~mask_s;
        end
      end
      default: begin
        addr_s    = addr_r;
        wr_data_s = wr_data_r;
      end
    endcase
  end

  // Latched command and row counter.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      op_r  <= 1'b0;
      x_r   <= '0;
      y_r   <= '0;
      row_r <= 4'd0;
    end else if (state_r == IDLE && bus.Cmd_Valid) begin
      op_r  <= bus.Cmd_Op;
      x_r   <= bus.Cmd_X;
      y_r   <= bus.Cmd_Y;
      row_r <= 4'd0;
    end else if (state_r == WR && !last_row_s) begin
      row_r <= row_r + 4'd1;
    end else begin
      row_r <= row_r;
    end
  end

  // Output registers.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      rdy_r     <= 1'b1;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      err_r     <= 1'b0;
      rd_en_r   <= 1'b0;
      wr_en_r   <= 1'b0;
      addr_r    <= '0;
      wr_data_r <= '0;
    end else begin
      rdy_r     <= rdy_s;
      busy_r    <= busy_s;
      done_r    <= done_s;
      err_r     <= err_s;
      rd_en_r   <= rd_en_s;
      wr_en_r   <= wr_en_s;
      addr_r    <= addr_s;
      wr_data_r <= wr_data_s;
    end
  end

  assign bus.Cmd_Ready   = rdy_r;
  assign bus.Busy        = busy_r;
  assign bus.Done        = done_r;
  assign bus.Err         = err_r;
  assign bus.Ram_Rd_En   = rd_en_r;
  assign bus.Ram_Wr_En   = wr_en_r;
  assign bus.Ram_Addr    = addr_r;
  assign bus.Ram_Wr_Data = wr_data_r;

endmodule
